// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR datapath: default sizing, state
// encoding and the address-width helper also used by the coefficient ROM.
package fir_pkg;

   localparam int WC_DEF       = 18;
   localparam int NUM_COEF_DEF = 17;
   localparam int WIN_DEF      = 16;
   localparam int WOUT_DEF     = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] TAIL = 2'd2;

   // Ceiling log2; the ROM sizes its address port with this same function,
   // so both sides of the coef_addr link always agree on the width.
   function automatic int log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line for the serial FIR: x[0] holds the newest sample,
// x[Num_coef-1] the oldest, with a combinational indexed read port.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int Win      = WIN_DEF,
   parameter int Num_coef = NUM_COEF_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        shift_en,
   input  logic [Win-1:0]              din,
   input  logic [log2(Num_coef)-1:0]   rd_idx,
   output logic [Win-1:0]              rd_data
);

   localparam int AW = log2(Num_coef);
   localparam logic [AW-1:0] LAST_IDX = AW'(Num_coef - 1);

   logic [Win-1:0] x_q [Num_coef];
   logic [Win-1:0] x_d [Num_coef];

   // Shift the whole line by one tap and insert the new sample when enabled.
   always_comb begin
      for (int k = 0; k < Num_coef; k++) begin
         x_d[k] = x_q[k];
      end
      if (shift_en) begin
         x_d[0] = din;
         for (int k = 1; k < Num_coef; k++) begin
            x_d[k] = x_q[k-1];
         end
      end
   end

   // Line storage; reset clears every tap so no old samples leak into a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < Num_coef; k++) begin
            x_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < Num_coef; k++) begin
            x_q[k] <= x_d[k];
         end
      end
   end

   // Indexed read, guarded so an out-of-range index returns zero.
   always_comb begin
      rd_data = '0;
      if (rd_idx <= LAST_IDX) begin
         rd_data = x_q[rd_idx];
      end
   end

endmodule

// File: rtl/fir_serial_mac.sv
// Serial single-multiplier FIR. One sample is accepted in IDLE, the ROM is
// swept over Num_coef addresses in MAC, and TAIL folds in the last product,
// rounds half up, saturates and pulses dout_valid for one cycle.
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int Wc       = WC_DEF,
   parameter int Num_coef = NUM_COEF_DEF,
   parameter int Win      = WIN_DEF,
   parameter int Wout     = WOUT_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [Win-1:0]              din,
   input  logic                        din_valid,
   output logic                        ready,
   output logic [log2(Num_coef)-1:0]   coef_addr,
   input  logic [Wc-1:0]               coef_data,
   output logic [Wout-1:0]             dout,
   output logic                        dout_valid
);

   localparam int AW   = log2(Num_coef);
   localparam int Wp   = Win + Wc;
   localparam int Wacc = Win + Wc + AW;

   localparam logic [AW-1:0]          LAST_CNT = AW'(Num_coef - 1);
   localparam logic signed [Wacc-1:0] ROUND_C  = Wacc'(longint'(1) << (Wc - 2));
   localparam logic signed [Wacc-1:0] SAT_MAX  = Wacc'((longint'(1) << (Wout - 1)) - 1);
   localparam logic signed [Wacc-1:0] SAT_MIN  = Wacc'(-(longint'(1) << (Wout - 1)));

   logic [1:0]              state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic signed [Wacc-1:0]  acc_q, acc_d;
   logic                    pv_q, pv_d;
   logic [Win-1:0]          x_pipe_q, x_pipe_d;
   logic [Wout-1:0]         dout_q, dout_d;
   logic                    dout_valid_q, dout_valid_d;

   logic                    shift_en;
   logic [Win-1:0]          rd_data;
   logic signed [Wp-1:0]    prod;
   logic signed [Wacc-1:0]  acc_f;
   logic signed [Wacc-1:0]  rounded;
   logic [Wout-1:0]         sat_val;

   fir_delay_line #(
      .Win      (Win),
      .Num_coef (Num_coef)
   ) u_delay_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .din      (din),
      .rd_idx   (cnt_q),
      .rd_data  (rd_data)
   );

   assign ready      = (state_q == IDLE);
   assign coef_addr  = (state_q == MAC) ? cnt_q : '0;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

   // Full-width signed product, running sum including it, and the rounded,
   // clamped form of that sum that becomes the output in TAIL.
   always_comb begin
      prod    = Wp'($signed(coef_data)) * Wp'($signed(x_pipe_q));
      acc_f   = acc_q + Wacc'(prod);
      rounded = (acc_f + ROUND_C) >>> (Wc - 1);
      if (rounded > SAT_MAX) begin
         sat_val = SAT_MAX[Wout-1:0];
      end else if (rounded < SAT_MIN) begin
         sat_val = SAT_MIN[Wout-1:0];
      end else begin
         sat_val = rounded[Wout-1:0];
      end
   end

   // Sequencing: accept in IDLE, one tap per cycle in MAC (the product lags
   // the address by one cycle, so pv masks the stale first ROM word), and
   // the last product is folded in during TAIL.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      pv_d         = pv_q;
      x_pipe_d     = x_pipe_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      shift_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               shift_en = 1'b1;
               acc_d    = '0;
               cnt_d    = '0;
               pv_d     = 1'b0;
               state_d  = MAC;
            end
         end
         MAC: begin
            x_pipe_d = rd_data;
            pv_d     = 1'b1;
            if (pv_q) begin
               acc_d = acc_f;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = TAIL;
            end
         end
         TAIL: begin
            dout_d       = sat_val;
            dout_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; an asynchronous reset abandons any computation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         pv_q         <= 1'b0;
         x_pipe_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         pv_q         <= pv_d;
         x_pipe_q     <= x_pipe_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: a registered ROM model, a tap-sum
// reference model computed at accept time, and a negedge monitor.
module tb_fir_serial_mac;

   localparam int NC = 17;
   localparam int WC = 18;
   localparam int LAT = NC + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        din_valid;
   logic        ready;
   logic [4:0]  coef_addr;
   logic [17:0] coef_data = '0;
   logic [15:0] dout;
   logic        dout_valid;

   logic [17:0] rom [NC];

   typedef struct {
      int value;
      int due;
   } exp_t;

   exp_t expq[$];
   int   acc_edges[$];
   int   hist[NC];
   int   cyc = 0;
   int   busy_until = 0;
   int   acc_count = 0;
   int   hold_val = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fir_serial_mac dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .ready      (ready),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   // Coefficient ROM with one cycle of registered read latency.
   always @(posedge clk) begin
      coef_data <= rom[coef_addr];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Filter output straight from the definition: sum of h[k]*x[k] over the
   // newest NC samples, round half up at the Q1.17 point, clamp to 16 bits.
   function automatic int modelOutput();
      longint sum;
      sum = 0;
      for (int k = 0; k < NC; k++) begin
         sum += longint'($signed(rom[k])) * longint'(hist[k]);
      end
      sum = (sum + (longint'(1) << (WC - 2))) >>> (WC - 1);
      if (sum > 32767) return 32767;
      if (sum < -32768) return -32768;
      return int'(sum);
   endfunction

   // Acceptance model: a sample is taken on an edge when the block has been
   // idle long enough; the expected result is queued with its due cycle.
   always @(posedge clk) begin
      exp_t e;
      if (rst_n && din_valid && cyc >= busy_until) begin
         for (int k = NC - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = int'($signed(din));
         e.value = modelOutput();
         e.due   = cyc + 1 + LAT;
         expq.push_back(e);
         busy_until = cyc + 1 + LAT;
         acc_count++;
         acc_edges.push_back(cyc + 1);
      end
      cyc = cyc + 1;
   end

   // Monitor: pops the scoreboard whenever the DUT presents an output.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         checkOutput("ready", int'(ready), int'(cyc >= busy_until));
         checkOutput("coef_addr_range", int'(coef_addr <= 5'd16), 1);
         if (expq.size() > 0 && expq[0].due < cyc) begin
            checkOutput("dout_valid_missing", 0, 1);
            void'(expq.pop_front());
         end
         if (dout_valid) begin
            if (expq.size() == 0) begin
               checkOutput("dout_valid_unexpected", 1, 0);
            end else begin
               e = expq.pop_front();
               checkOutput("dout", int'($signed(dout)), e.value);
               checkOutput("latency_cycle", cyc, e.due);
               hold_val = e.value;
            end
         end
         checkOutput("dout_hold", int'($signed(dout)), hold_val);
      end
   end

   task automatic applyStimulus(input int d);
      int start;
      bit got;
      start     = acc_count;
      got       = 1'b0;
      din       = 16'(d);
      din_valid = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk);
         #2;
         if (acc_count != start) got = 1'b1;
      end
      din_valid = 1'b0;
      checkOutput("accept_bound", int'(got), 1);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 60) begin
         @(posedge clk);
         #2;
         n++;
      end
      checkOutput("drain_bound", expq.size(), 0);
      @(posedge clk);
      #2;
   endtask

   task automatic setTap(input int tap, input int val);
      for (int k = 0; k < NC; k++) rom[k] = '0;
      rom[tap] = 18'(val);
   endtask

   task automatic setAll(input int val);
      for (int k = 0; k < NC; k++) rom[k] = 18'(val);
   endtask

   task automatic resetPulse();
      din_valid = 1'b0;
      rst_n     = 1'b0;
      for (int k = 0; k < NC; k++) hist[k] = 0;
      expq.delete();
      busy_until = 0;
      hold_val   = 0;
      #1;
      checkOutput("reset_ready", int'(ready), 1);
      checkOutput("reset_dout", int'($signed(dout)), 0);
      checkOutput("reset_dout_valid", int'(dout_valid), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      setAll(0);
      for (int k = 0; k < NC; k++) hist[k] = 0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("init_ready", int'(ready), 1);
      checkOutput("init_dout", int'($signed(dout)), 0);
      checkOutput("init_dout_valid", int'(dout_valid), 0);
      checkOutput("init_coef_addr", int'(coef_addr), 0);
      rst_n = 1'b1;

      $display("[TB] impulse and latency");
      setTap(0, 65536);
      applyStimulus(16384);
      repeat (3) applyStimulus(0);
      waitDrain();

      $display("[TB] tap walk");
      setTap(3, 65536);
      applyStimulus(16384);
      repeat (3) applyStimulus(0);
      waitDrain();

      $display("[TB] rounding");
      setTap(0, 65536);
      applyStimulus(1);
      applyStimulus(-1);
      waitDrain();

      $display("[TB] saturation");
      setAll(131071);
      repeat (NC) applyStimulus(32767);
      repeat (NC) applyStimulus(-32768);
      waitDrain();

      $display("[TB] random coefficients and samples");
      for (int k = 0; k < NC; k++) rom[k] = 18'($urandom);
      for (int i = 0; i < 25; i++) begin
         applyStimulus(int'($signed(16'($urandom))));
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #2;
      end
      waitDrain();

      $display("[TB] back-to-back requests");
      setAll(3000);
      acc_edges.delete();
      begin
         int start_cnt;
         start_cnt = acc_count;
         din_valid = 1'b1;
         for (int i = 0; i < 3 * (LAT + 1); i++) begin
            din = 16'(100 + i);
            @(posedge clk);
            #2;
         end
         din_valid = 1'b0;
         checkOutput("accept_count", acc_count - start_cnt, 3);
         if (acc_edges.size() == 3) begin
            checkOutput("accept_gap1", acc_edges[1] - acc_edges[0], LAT + 1);
            checkOutput("accept_gap2", acc_edges[2] - acc_edges[1], LAT + 1);
         end else begin
            checkOutput("accept_edges", acc_edges.size(), 3);
         end
      end
      waitDrain();

      $display("[TB] reset during accumulation");
      setAll(4096);
      repeat (3) applyStimulus(int'($signed(16'($urandom))));
      applyStimulus(12345);
      repeat (8) @(posedge clk);
      #2;
      resetPulse();
      repeat (LAT + 4) @(posedge clk);
      #2;
      setTap(0, 65536);
      applyStimulus(16384);
      repeat (3) applyStimulus(0);
      waitDrain();
      setAll(4096);
      applyStimulus(100);
      waitDrain();

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
